wb_int_ctrl: RTL and testbench
==============================

Name: wb_int_ctrl

Overview:
Parametrised Wishbone-slave interrupt controller. It replaces the hard-wired INT/CAUSE priority chain at the top level.
- Accepts N_SRC asynchronous interrupt sources, each with per-source mask and edge/level mode.
- Latches pending requests and drives the CPU INT and Cause_in inputs from a fixed-priority encoder.
- Sits on the WB_intercon as one slave: software reads cause/pending and clears pending through bus accesses.

Parameters:
N_SRC, 8, number of interrupt sources (1..32).
CAUSE_BASE, 32'h0, value added to the winning source index to form CPU_CAUSE.
MASK_RST, 32'h0, reset value of the MASK register (bits >= N_SRC ignored).
MODE_RST, 32'hFFFFFFFF, reset value of the MODE register (1 = edge, 0 = level).

Ports:
clk  input  1  system clock (clk25 domain at top)
RSTN  input  1  asynchronous reset, active-low
irq_src  input  N_SRC  raw interrupt sources, asynchronous, active-high
STB  input  1  Wishbone strobe from intercon
WE  input  1  Wishbone write enable
ADDR  input  32  byte address; only ADDR[3:2] decoded
DAT_I  input  32  write data
DAT_O  output  32  read data
ACK  output  1  Wishbone acknowledge
CPU_INT  output  1  interrupt request to CPU, registered
CPU_CAUSE  output  32  cause code to CPU, registered

Behaviour:
Reset:
- RSTN low asynchronously clears synchronisers, PENDING, ACK, DAT_O, CPU_INT and CPU_CAUSE to 0.
- MASK is set to MASK_RST and MODE to MODE_RST.
- Reset asserted mid-transfer aborts the transfer; no ACK is issued for it.

Synchronisation:
- Each irq_src bit passes through a 2-flop synchroniser (s1, s2) and a delay flop s2_d.
- Edge-mode event = s2 & ~s2_d.

Register map (word offset = ADDR[3:2]):
- 0 PENDING: read returns pending bits; write-1-to-clear, edge-mode bits only.
- 1 MASK: read/write; 1 = enabled.
- 2 MODE: read/write; 1 = edge, 0 = level.
- 3 CAUSE: read-only, returns current CPU_CAUSE; writes ignored.
- Bits [31:N_SRC] read 0 and ignore writes.

Pending update (per bit, per cycle):
- Level mode: pending = s2. W1C has no effect.
- Edge mode: set on edge event, cleared by W1C.
- Edge event and W1C in the same cycle: set wins, bit stays 1.
- Switching MODE from level to edge keeps the current pending value.

Interrupt output:
- Active vector = PENDING & MASK.
- Priority: lowest index wins.
- Next cycle: CPU_INT = |active; CPU_CAUSE = CAUSE_BASE + winning index, or 32'h0 when none active.
- Latency: source rise is sampled at edge 1, pending sets at edge 3, CPU_INT/CPU_CAUSE update at edge 4.
- Masking or clearing drops CPU_INT one cycle after the register write.

Bus handshake:
- ACK <= STB & ~ACK, so it is a one-cycle pulse the cycle after STB is seen.
- If STB is held, a further ACK follows every other cycle; each ACK ends one transfer.
- Writes commit on the same edge that raises ACK.
- DAT_O is registered and valid while ACK = 1; it holds its last value otherwise.
- STB dropped before ACK: no write occurs.

Arithmetic:
- CAUSE_BASE + index is 32-bit with wrap-around, no saturation.

Test Plan:
- Reset with defaults -> CPU_INT = 0, CPU_CAUSE = 0, MASK reads 0, MODE reads 32'h000000FF (N_SRC = 8).
- Write MASK = 8'h0C; pulse irq_src[3] high for 1 cycle (edge mode) -> PENDING reads 8'h08; CPU_INT = 1 four cycles after the rise; CPU_CAUSE = 3. Write PENDING = 8'h08 -> CPU_INT = 0 one cycle after ACK.
- Raise irq_src[2] and irq_src[3] together with MASK = 8'h0C -> CPU_CAUSE = 2. Clear bit 2 -> CPU_CAUSE = 3, CPU_INT stays 1.
- MODE = 8'hFE (bit 0 level), MASK = 1, hold irq_src[0] high -> W1C of bit 0 leaves PENDING = 1. Drop the source -> CPU_INT = 0 four cycles later.
- W1C of bit 5 issued on the same cycle as a bit-5 edge event -> PENDING[5] remains 1.
- CAUSE_BASE = 32'h10, irq_src[1] enabled -> CPU_CAUSE = 32'h11. Hold STB 4 cycles -> ACK pulses on cycles 2 and 4 only. Assert RSTN low mid-transfer -> ACK = 0 immediately.

Source files
------------

// File: rtl/wb_int_ctrl_if.sv
// Wishbone slave bus between the intercon and the interrupt controller.
// The master modport drives the request; the slave modport returns data and acknowledge.
interface wb_int_ctrl_if;
  logic        STB;
  logic        WE;
  logic [31:0] ADDR;
  logic [31:0] DAT_I;
  logic [31:0] DAT_O;
  logic        ACK;

  modport master (output STB, WE, ADDR, DAT_I, input DAT_O, ACK);
  modport slave  (input STB, WE, ADDR, DAT_I, output DAT_O, ACK);
endinterface

// File: rtl/wb_int_ctrl.sv
// Wishbone-slave interrupt controller: synchronises N_SRC sources, latches pending
// requests and presents a fixed-priority INT/CAUSE pair to the CPU.
module wb_int_ctrl #(
  parameter int unsigned N_SRC      = 8,
  parameter logic [31:0] CAUSE_BASE = 32'h0000_0000,
  parameter logic [31:0] MASK_RST   = 32'h0000_0000,
  parameter logic [31:0] MODE_RST   = 32'hFFFF_FFFF
) (
  input  logic             clk,
  input  logic             RSTN,
  input  logic [N_SRC-1:0] irq_src,
  wb_int_ctrl_if.slave     bus,
  output logic             CPU_INT,
  output logic [31:0]      CPU_CAUSE
);
  localparam logic [1:0] REG_PENDING = 2'd0;
  localparam logic [1:0] REG_MASK    = 2'd1;
  localparam logic [1:0] REG_MODE    = 2'd2;
  localparam logic [1:0] REG_CAUSE   = 2'd3;

  logic [N_SRC-1:0] s1_r;
  logic [N_SRC-1:0] s2_r;
  logic [N_SRC-1:0] s2_d_r;
  logic [N_SRC-1:0] pending_r;
  logic [N_SRC-1:0] mask_r;
  logic [N_SRC-1:0] mode_r;
  logic             ack_r;
  logic [31:0]      dat_o_r;
  logic             cpu_int_r;
  logic [31:0]      cpu_cause_r;

  logic [1:0]       word_s;
  logic             xfer_s;
  logic             wr_s;
  logic [N_SRC-1:0] wdat_s;
  logic [N_SRC-1:0] edge_s;
  logic [N_SRC-1:0] w1c_s;
  logic [N_SRC-1:0] pending_nxt_s;
  logic [N_SRC-1:0] active_s;
  logic [4:0]       win_s;
  logic [31:0]      cause_nxt_s;
  logic [31:0]      rdat_s;
  logic             unused_s;

  // A transfer is accepted only while ACK is low, so a held STB yields every-other-cycle ACKs.
  assign word_s   = bus.ADDR[3:2];
  assign xfer_s   = bus.STB & ~ack_r;
  assign wr_s     = xfer_s & bus.WE;
  assign wdat_s   = bus.DAT_I[N_SRC-1:0];
  assign edge_s   = s2_r & ~s2_d_r;
  assign active_s = pending_r & mask_r;
  assign unused_s = ^{bus.ADDR, bus.DAT_I};

  // Pending next state: level bits follow the source, edge bits set-dominant over W1C.
  always_comb begin
    w1c_s = '0;
    if (wr_s && (word_s == REG_PENDING)) begin
      w1c_s = wdat_s;
    end else begin
      w1c_s = '0;
    end
    pending_nxt_s = (mode_r & ((pending_r & ~w1c_s) | edge_s)) | (~mode_r & s2_r);
  end

  // Register read mux; unimplemented upper bits read as zero.
  always_comb begin
    rdat_s = 32'h0000_0000;
    case (word_s)
      REG_PENDING: rdat_s[N_SRC-1:0] = pending_r;
      REG_MASK:    rdat_s[N_SRC-1:0] = mask_r;
      REG_MODE:    rdat_s[N_SRC-1:0] = mode_r;
      REG_CAUSE:   rdat_s            = cpu_cause_r;
      default:     rdat_s            = 32'h0000_0000;
    endcase
  end

  // Fixed-priority encoder: scanning downward leaves the lowest active index.
  always_comb begin
    win_s = 5'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      win_s = active_s[i] ? 5'(i) : win_s;
    end
    if (|active_s) begin
      cause_nxt_s = CAUSE_BASE + {27'd0, win_s};
    end else begin
      cause_nxt_s = 32'h0000_0000;
    end
  end

  // Two-flop synchroniser plus delay stage for edge detection.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      s1_r   <= '0;
      s2_r   <= '0;
      s2_d_r <= '0;
    end else begin
      s1_r   <= irq_src;
      s2_r   <= s1_r;
      s2_d_r <= s2_r;
    end
  end

  // Pending, mask and mode registers; writes commit on the edge that raises ACK.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      pending_r <= '0;
      mask_r    <= MASK_RST[N_SRC-1:0];
      mode_r    <= MODE_RST[N_SRC-1:0];
    end else begin
      pending_r <= pending_nxt_s;
      if (wr_s && (word_s == REG_MASK)) begin
        mask_r <= wdat_s;
      end
      if (wr_s && (word_s == REG_MODE)) begin
        mode_r <= wdat_s;
      end
    end
  end

  // Bus response: single-cycle ACK, read data captured with it and held afterwards.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      ack_r   <= 1'b0;
      dat_o_r <= 32'h0000_0000;
    end else begin
      ack_r <= bus.STB & ~ack_r;
      if (xfer_s) begin
        dat_o_r <= rdat_s;
      end
    end
  end

  // Registered CPU interrupt request and cause code.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      cpu_int_r   <= 1'b0;
      cpu_cause_r <= 32'h0000_0000;
    end else begin
      cpu_int_r   <= |active_s;
      cpu_cause_r <= cause_nxt_s;
    end
  end

  assign bus.ACK   = ack_r;
  assign bus.DAT_O = dat_o_r;
  assign CPU_INT   = cpu_int_r;
  assign CPU_CAUSE = cpu_cause_r;
endmodule

// File: tb/tb_wb_int_ctrl.sv
// Self-checking bench for wb_int_ctrl: register table, hand-timed corner sequences,
// then randomized traffic against a behavioural model of the controller.
module tb_wb_int_ctrl;
  localparam logic [31:0] BASE = 32'h0000_0010;

  logic        clk;
  logic        RSTN;
  logic [7:0]  irq_src;
  logic        CPU_INT;
  logic [31:0] CPU_CAUSE;
  int          checks;
  int          failures;

  wb_int_ctrl_if bif ();

  wb_int_ctrl #(.N_SRC(8), .CAUSE_BASE(BASE)) dut (
    .clk       (clk),
    .RSTN      (RSTN),
    .irq_src   (irq_src),
    .bus       (bif),
    .CPU_INT   (CPU_INT),
    .CPU_CAUSE (CPU_CAUSE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    logic [1:0]  word;
    logic [31:0] wdat;
    logic [31:0] exp;
  } vec_t;

  // behavioural model state
  logic [7:0]  m_pend, m_mask, m_mode;
  logic [7:0]  m_hist[$];
  bit          m_int, m_ack;
  logic [31:0] m_cause, m_dat;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_op(input bit we, input logic [1:0] w, input logic [31:0] wd,
                        output logic [31:0] rd);
    logic [31:0] a;
    a = $urandom();
    a[3:2] = w;
    bif.STB = 1'b1; bif.WE = we; bif.ADDR = a; bif.DAT_I = wd;
    tick();
    chk("bus_ack", 32'(bif.ACK), 32'h1);
    rd = bif.DAT_O;
    bif.STB = 1'b0; bif.WE = 1'b0;
  endtask

  task automatic model_reset();
    m_pend = 8'h00; m_mask = 8'h00; m_mode = 8'hFF;
    m_int = 1'b0; m_ack = 1'b0; m_cause = 32'h0; m_dat = 32'h0;
    m_hist = {8'h00, 8'h00, 8'h00};
  endtask

  // One clock edge of the controller as seen from its specified rules.
  task automatic model_step(input logic [7:0] irq, input bit stb, input bit we,
                            input logic [31:0] addr, input logic [31:0] wd);
    logic [7:0] s2, s2d, act, low, npend;
    logic [1:0] w;
    bit xfer, clr;
    logic [31:0] rd;
    s2d = m_hist[0];
    s2  = m_hist[1];
    m_hist.push_back(irq);
    void'(m_hist.pop_front());
    w = addr[3:2];
    xfer = stb && !m_ack;
    for (int b = 0; b < 8; b++) begin
      clr = xfer && we && (w == 2'd0) && wd[b];
      if (!m_mode[b])            npend[b] = s2[b];
      else if (s2[b] && !s2d[b]) npend[b] = 1'b1;
      else if (clr)              npend[b] = 1'b0;
      else                       npend[b] = m_pend[b];
    end
    act = m_pend & m_mask;
    low = act & (~act + 8'd1);
    case (w)
      2'd0:    rd = {24'h0, m_pend};
      2'd1:    rd = {24'h0, m_mask};
      2'd2:    rd = {24'h0, m_mode};
      default: rd = m_cause;
    endcase
    if (xfer) m_dat = rd;
    m_int   = (act != 8'h00);
    m_cause = (act != 8'h00) ? BASE + 32'($clog2(low)) : 32'h0;
    if (xfer && we && w == 2'd1) m_mask = wd[7:0];
    if (xfer && we && w == 2'd2) m_mode = wd[7:0];
    m_pend = npend;
    m_ack  = stb && !m_ack;
  endtask

  initial begin
    vec_t vecs[12];
    logic [31:0] rd;
    checks = 0; failures = 0;
    RSTN = 1'b0; irq_src = 8'h00;
    bif.STB = 1'b0; bif.WE = 1'b0; bif.ADDR = 32'h0; bif.DAT_I = 32'h0;

    vecs[0]  = '{1'b0, 2'd1, 32'h0000_0000, 32'h0000_0000};
    vecs[1]  = '{1'b0, 2'd2, 32'h0000_0000, 32'h0000_00FF};
    vecs[2]  = '{1'b0, 2'd0, 32'h0000_0000, 32'h0000_0000};
    vecs[3]  = '{1'b0, 2'd3, 32'h0000_0000, 32'h0000_0000};
    vecs[4]  = '{1'b1, 2'd1, 32'hFFFF_FF0C, 32'h0000_0000};
    vecs[5]  = '{1'b0, 2'd1, 32'h0000_0000, 32'h0000_000C};
    vecs[6]  = '{1'b1, 2'd2, 32'h0000_00FE, 32'h0000_0000};
    vecs[7]  = '{1'b0, 2'd2, 32'h0000_0000, 32'h0000_00FE};
    vecs[8]  = '{1'b1, 2'd2, 32'hABCD_00FF, 32'h0000_0000};
    vecs[9]  = '{1'b0, 2'd2, 32'h0000_0000, 32'h0000_00FF};
    vecs[10] = '{1'b1, 2'd3, 32'h0000_1234, 32'h0000_0000};
    vecs[11] = '{1'b0, 2'd3, 32'h0000_0000, 32'h0000_0000};

    tick(); tick();
    @(negedge clk) RSTN = 1'b1;
    chk("rst_int", 32'(CPU_INT), 32'h0);
    chk("rst_cause", CPU_CAUSE, 32'h0);
    chk("rst_ack", 32'(bif.ACK), 32'h0);
    chk("rst_dat", bif.DAT_O, 32'h0);

    for (int i = 0; i < 12; i++) begin
      bus_op(vecs[i].we, vecs[i].word, vecs[i].wdat, rd);
      if (!vecs[i].we) chk($sformatf("vec%0d", i), rd, vecs[i].exp);
      tick();
      chk("ack_pulse", 32'(bif.ACK), 32'h0);
    end

    // edge source 3: latency of four edges, then W1C
    irq_src = 8'h08; tick(); irq_src = 8'h00;
    chk("lat_e1", 32'(CPU_INT), 32'h0); tick();
    chk("lat_e2", 32'(CPU_INT), 32'h0); tick();
    chk("lat_e3", 32'(CPU_INT), 32'h0); tick();
    chk("lat_e4", 32'(CPU_INT), 32'h1);
    chk("cause3", CPU_CAUSE, BASE + 32'd3);
    tick();
    bus_op(1'b0, 2'd0, 32'h0, rd); chk("pend08", rd, 32'h08); tick();
    bus_op(1'b1, 2'd0, 32'h08, rd);
    chk("clr_ackcyc", 32'(CPU_INT), 32'h1); tick();
    chk("clr_int", 32'(CPU_INT), 32'h0);
    chk("clr_cause0", CPU_CAUSE, 32'h0);

    // priority between sources 2 and 3
    irq_src = 8'h0C; tick(); tick(); tick(); tick();
    chk("prio_cause2", CPU_CAUSE, BASE + 32'd2);
    bus_op(1'b1, 2'd0, 32'h04, rd); tick();
    chk("prio_cause3", CPU_CAUSE, BASE + 32'd3);
    chk("prio_int", 32'(CPU_INT), 32'h1);
    bus_op(1'b1, 2'd0, 32'h08, rd); tick();
    chk("prio_none", 32'(CPU_INT), 32'h0);
    irq_src = 8'h00; tick(); tick(); tick();

    // level mode on source 0
    bus_op(1'b1, 2'd2, 32'hFE, rd); tick();
    bus_op(1'b1, 2'd1, 32'h01, rd); tick();
    irq_src = 8'h01; tick(); tick(); tick(); tick(); tick();
    chk("lvl_int", 32'(CPU_INT), 32'h1);
    chk("lvl_cause", CPU_CAUSE, BASE);
    bus_op(1'b1, 2'd0, 32'h01, rd); tick();
    bus_op(1'b0, 2'd0, 32'h0, rd); chk("lvl_w1c", rd, 32'h01); tick();
    irq_src = 8'h00; tick(); tick(); tick();
    chk("lvl_drop3", 32'(CPU_INT), 32'h1); tick();
    chk("lvl_drop4", 32'(CPU_INT), 32'h0);
    bus_op(1'b1, 2'd2, 32'hFF, rd); tick();

    // edge event and W1C on the same edge for source 5
    bus_op(1'b1, 2'd1, 32'h20, rd); tick();
    irq_src = 8'h20; tick(); tick(); tick(); tick();
    chk("b5_cause", CPU_CAUSE, BASE + 32'd5);
    irq_src = 8'h00; tick(); tick(); tick();
    irq_src = 8'h20; tick(); tick();
    bus_op(1'b1, 2'd0, 32'h20, rd); tick();
    bus_op(1'b0, 2'd0, 32'h0, rd); chk("b5_setwins", rd, 32'h20); tick();
    bus_op(1'b1, 2'd0, 32'h20, rd); tick();
    bus_op(1'b0, 2'd0, 32'h0, rd); chk("b5_cleared", rd, 32'h00); tick();
    irq_src = 8'h00; tick();

    // held STB: ACK every other cycle
    bif.STB = 1'b1; bif.WE = 1'b0; bif.ADDR = 32'h4;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("held_ack%0d", i), 32'(bif.ACK), (i % 2 == 0) ? 32'h1 : 32'h0);
    end
    bif.STB = 1'b0; tick();

    // reset while ACK is high clears it at once
    bif.STB = 1'b1; tick();
    chk("pre_rst_ack", 32'(bif.ACK), 32'h1);
    #2 RSTN = 1'b0;
    #1 chk("rst_ack_now", 32'(bif.ACK), 32'h0);
    chk("rst_dat_now", bif.DAT_O, 32'h0);
    bif.STB = 1'b0;
    @(negedge clk) RSTN = 1'b1;
    tick();

    // reset before ACK aborts the write
    bus_op(1'b1, 2'd1, 32'h0F, rd); tick();
    bif.STB = 1'b1; bif.WE = 1'b1; bif.ADDR = 32'h4; bif.DAT_I = 32'hFF;
    #2 RSTN = 1'b0;
    tick();
    chk("abort_ack", 32'(bif.ACK), 32'h0);
    bif.STB = 1'b0; bif.WE = 1'b0;
    @(negedge clk) RSTN = 1'b1;
    tick();
    bus_op(1'b0, 2'd1, 32'h0, rd); chk("abort_mask", rd, 32'h0); tick();

    // randomized traffic against the model
    RSTN = 1'b0; irq_src = 8'h00; bif.STB = 1'b0;
    tick(); tick();
    @(negedge clk) RSTN = 1'b1;
    model_reset();
    for (int c = 0; c < 800; c++) begin
      irq_src = irq_src ^ (8'($urandom()) & 8'($urandom()) & 8'($urandom()));
      bif.STB = 1'($urandom_range(0, 1));
      bif.WE = 1'($urandom_range(0, 1));
      bif.ADDR = $urandom();
      bif.DAT_I = $urandom();
      model_step(irq_src, bif.STB, bif.WE, bif.ADDR, bif.DAT_I);
      tick();
      chk("rnd_int", 32'(CPU_INT), 32'(m_int));
      chk("rnd_cause", CPU_CAUSE, m_cause);
      chk("rnd_ack", 32'(bif.ACK), 32'(m_ack));
      chk("rnd_dat", bif.DAT_O, m_dat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
